player_motion_ctrl: RTL and testbench

// - Parametrised player physics/state engine: fixed-point vertical velocity with gravity, N-jump
//   (MAX_JUMPS), step-based run and respawn load. Updates once per frame `tick`.
// - Sits between key/collision logic and the sprite renderer; drives the player position, facing and action.

---
 rtl/player_motion_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// ============================================================================
// Module   : player_motion_ctrl
// Purpose  : Per-frame player physics and state engine. It provides a
//            fixed-point vertical velocity with gravity, N-jump (MAX_JUMPS),
//            step-based horizontal run and respawn loading. Physics advances
//            once per `tick` strobe. All outputs are registered.
// Config   : `define JUMP_CUT_EN to enable variable jump height. When it is
//            defined, releasing jump while rising fast caps upward velocity
//            at -CUT_V.
// Ports    : clk, rst_n          clock, async active-low reset
//            tick                frame strobe (one clk)
//            keys[2:0]           left/right/jump ([3] ignored)
//            is_collide[3:0]     up/down/left/right contact, valid at tick
//            respawn, spawn_x/y  load spawn position (wins over tick)
//            direction           0 left, 1 right
//            action              00 idle, 01 run, 10 rise, 11 fall
//            pos_x/pos_y         integer pixel position (y grows downward)
//            vel_y               signed velocity, FRAC fraction bits
//            jumps_left          remaining jumps
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_motion_ctrl #(
  parameter int PW        = 10,
  parameter int FRAC      = 4,
  parameter int VW        = 8,
  parameter int INIT_X    = 200,
  parameter int INIT_Y    = 556,
  parameter int X_MAX     = 799,
  parameter int Y_MAX     = 599,
  parameter int RUN_STEP  = 2,
  parameter int GRAVITY   = 3,
  parameter int JUMP_V    = 64,
  parameter int JUMP2_V   = 52,
  parameter int VY_MAX    = 96,
  parameter int MAX_JUMPS = 2,
  parameter int CUT_V     = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tick,
  input  logic [3:0]                         keys,
  input  logic [3:0]                         is_collide,
  input  logic                               respawn,
  input  logic [PW-1:0]                      spawn_x,
  input  logic [PW-1:0]                      spawn_y,
  output logic                               direction,
  output logic [1:0]                         action,
  output logic [PW-1:0]                      pos_x,
  output logic [PW-1:0]                      pos_y,
  output logic [VW-1:0]                      vel_y,
  output logic [$clog2(MAX_JUMPS+1)-1:0]     jumps_left
);

  localparam int JW = $clog2(MAX_JUMPS + 1);
  // Y accumulator {pos_y, frac} plus a guard bit and a sign bit.
  localparam int SW = PW + FRAC + 2;

  localparam logic signed [VW-1:0] C_JUMP1   = VW'(-JUMP_V);
  localparam logic signed [VW-1:0] C_JUMP2   = VW'(-JUMP2_V);
  localparam logic signed [VW-1:0] C_CUT_NEG = VW'(-CUT_V);
  localparam logic signed [VW:0]   C_GRAV    = (VW+1)'(GRAVITY);
  localparam logic signed [VW:0]   C_VYMAX   = (VW+1)'(VY_MAX);

  typedef enum logic [0:0] {
    ST_GROUND = 1'b0,
    ST_AIR    = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          pos_x_q, pos_x_d;
  logic [PW-1:0]          pos_y_q, pos_y_d;
  logic [FRAC-1:0]        frac_q, frac_d;
  logic signed [VW-1:0]   vel_q, vel_d;
  logic [JW-1:0]          jumps_q, jumps_d;
  logic                   dir_q, dir_d;
  logic [1:0]             act_q, act_d;
  logic                   pend_q, pend_d;
  logic                   key_prev_q;

  logic                   w_left, w_right, w_move, w_rise, w_jump;
  logic [PW:0]            w_x_sum;
  logic signed [VW:0]     w_vy_grav;
  logic signed [VW-1:0]   w_vel_n;
  logic signed [SW-1:0]   w_y_sum;

  assign w_left  = keys[2];
  assign w_right = keys[1];
  assign w_move  = w_left ^ w_right;
  assign w_rise  = keys[0] & ~key_prev_q;

  logic unused_keys3;
  assign unused_keys3 = keys[3];

`ifndef JUMP_CUT_EN
  logic [VW-1:0] unused_cut;
  assign unused_cut = C_CUT_NEG;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_GROUND;
      pos_x_q    <= PW'(INIT_X);
      pos_y_q    <= PW'(INIT_Y);
      frac_q     <= '0;
      vel_q      <= '0;
      jumps_q    <= JW'(MAX_JUMPS);
      dir_q      <= 1'b1;
      act_q      <= 2'b00;
      pend_q     <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      frac_q     <= frac_d;
      vel_q      <= vel_d;
      jumps_q    <= jumps_d;
      dir_q      <= dir_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      key_prev_q <= keys[0];
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    frac_d    = frac_q;
    vel_d     = vel_q;
    jumps_d   = jumps_q;
    dir_d     = dir_q;
    act_d     = act_q;
    pend_d    = pend_q | w_rise;
    w_x_sum   = '0;
    w_vy_grav = '0;
    w_vel_n   = vel_q;
    w_y_sum   = '0;
    // A press arriving in the same clk as the tick is consumed by that tick.
    w_jump    = (pend_q | w_rise) && (jumps_q != '0);

    if (respawn) begin
      pos_x_d = spawn_x;
      pos_y_d = spawn_y;
      frac_d  = '0;
      vel_d   = '0;
      state_d = ST_AIR;
      act_d   = 2'b11;
      jumps_d = JW'(MAX_JUMPS - 1);
      pend_d  = 1'b0;
    end else if (tick) begin
      // Every tick consumes the pending press, usable or not, so an
      // exhausted press cannot fire later after landing.
      pend_d = 1'b0;

      // Horizontal
      if (w_move) begin
        dir_d = w_right;
      end
      if (w_move && w_right && !is_collide[0]) begin
        w_x_sum = {1'b0, pos_x_q} + (PW+1)'(RUN_STEP);
        pos_x_d = (w_x_sum > (PW+1)'(X_MAX)) ? PW'(X_MAX) : w_x_sum[PW-1:0];
      end else if (w_move && w_left && !is_collide[1]) begin
        pos_x_d = (pos_x_q < PW'(RUN_STEP)) ? '0 : pos_x_q - PW'(RUN_STEP);
      end

      // Vertical velocity: jump impulse, walk-off or gravity
      if (w_jump) begin
        w_vel_n = (state_q == ST_GROUND) ? C_JUMP1 : C_JUMP2;
        jumps_d = jumps_q - JW'(1);
        state_d = ST_AIR;
      end else if (state_q == ST_GROUND) begin
        if (!is_collide[2]) begin
          // Walking off a ledge spends the ground jump.
          state_d = ST_AIR;
          jumps_d = JW'(MAX_JUMPS - 1);
        end
      end else begin
`ifdef JUMP_CUT_EN
        if (!keys[0] && (w_vel_n < C_CUT_NEG)) begin
          w_vel_n = C_CUT_NEG;
        end
`endif
        w_vy_grav = $signed({w_vel_n[VW-1], w_vel_n}) + C_GRAV;
        w_vel_n   = (w_vy_grav > C_VYMAX) ? VW'(VY_MAX) : w_vy_grav[VW-1:0];
      end

      // Position step with ceiling / floor contact
      if (w_vel_n[VW-1] && is_collide[3]) begin
        w_vel_n = '0;
      end else if (!w_vel_n[VW-1] && is_collide[2] && (state_q == ST_AIR)) begin
        w_vel_n = '0;
        frac_d  = '0;
        state_d = ST_GROUND;
        jumps_d = JW'(MAX_JUMPS);
      end else begin
        w_y_sum = $signed({2'b00, pos_y_q, frac_q})
                + $signed({{(SW-VW){w_vel_n[VW-1]}}, w_vel_n});
        if (w_y_sum[SW-1]) begin
          pos_y_d = '0;
          frac_d  = '0;
        end else if (w_y_sum[SW-2:FRAC] > (PW+1)'(Y_MAX)) begin
          pos_y_d = PW'(Y_MAX);
          frac_d  = '0;
        end else begin
          pos_y_d = w_y_sum[PW+FRAC-1:FRAC];
          frac_d  = w_y_sum[FRAC-1:0];
        end
      end

      vel_d = w_vel_n;
      if (state_d == ST_AIR) begin
        act_d = w_vel_n[VW-1] ? 2'b10 : 2'b11;
      end else begin
        act_d = w_move ? 2'b01 : 2'b00;
      end
    end
  end

  assign direction  = dir_q;
  assign action     = act_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign vel_y      = vel_q;
  assign jumps_left = jumps_q;

endmodule

`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
// ============================================================================
// Module   : tb_player_motion_ctrl
// Purpose  : Self-checking bench for player_motion_ctrl. It runs directed
//            scenarios followed by randomized frames, all compared against a
//            behavioural integer model of the player physics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_player_motion_ctrl;

  localparam int MAXJ = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] keys = 4'b0;
  logic [3:0] is_collide = 4'b0;
  logic       respawn = 1'b0;
  logic [9:0] spawn_x = '0;
  logic [9:0] spawn_y = '0;
  wire        direction;
  wire  [1:0] action;
  wire  [9:0] pos_x;
  wire  [9:0] pos_y;
  wire  [7:0] vel_y;
  wire  [1:0] jumps_left;

  player_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .keys       (keys),
    .is_collide (is_collide),
    .respawn    (respawn),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .direction  (direction),
    .action     (action),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .vel_y      (vel_y),
    .jumps_left (jumps_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: y is tracked in sixteenths of a pixel as one integer.
  int m_x, m_yacc, m_vy, m_jumps, m_dir, m_air, m_act, m_kprev, m_pend;

  task automatic model_reset();
    m_x = 200; m_yacc = 556 * 16; m_vy = 0; m_jumps = MAXJ;
    m_dir = 1; m_air = 0; m_act = 0; m_kprev = 0; m_pend = 0;
  endtask

  task automatic model_clk(input logic tk, input logic [3:0] k,
                           input logic [3:0] col, input logic rsp,
                           input int sx, input int sy);
    int rise, pend, l, r, was_air;
    rise    = (k[0] && !m_kprev) ? 1 : 0;
    m_kprev = k[0];
    if (rsp) begin
      m_x = sx; m_yacc = sy * 16; m_vy = 0; m_air = 1; m_act = 3;
      m_jumps = MAXJ - 1; m_pend = 0;
    end else if (tk) begin
      pend   = m_pend | rise;
      m_pend = 0;
      l = k[2]; r = k[1];
      if (l != r) m_dir = r;
      if (r && !l && !col[0]) m_x = (m_x + 2 > 799) ? 799 : m_x + 2;
      if (l && !r && !col[1]) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
      was_air = m_air;
      if (pend && m_jumps > 0) begin
        m_vy = was_air ? -52 : -64;
        m_jumps--;
        m_air = 1;
      end else if (!was_air) begin
        if (!col[2]) begin
          m_air = 1;
          m_jumps = MAXJ - 1;
        end
      end else begin
`ifdef JUMP_CUT_EN
        if (!k[0] && m_vy < -16) m_vy = -16;
`endif
        m_vy = (m_vy + 3 > 96) ? 96 : m_vy + 3;
      end
      if (m_vy < 0 && col[3]) begin
        m_vy = 0;
      end else if (m_vy >= 0 && col[2] && was_air) begin
        m_vy = 0; m_yacc = (m_yacc / 16) * 16; m_air = 0; m_jumps = MAXJ;
      end else begin
        m_yacc += m_vy;
        if (m_yacc < 0) m_yacc = 0;
        else if (m_yacc >= 600 * 16) m_yacc = 599 * 16;
      end
      m_act = m_air ? ((m_vy < 0) ? 2 : 3) : ((l != r) ? 1 : 0);
    end else begin
      m_pend = m_pend | rise;
    end
  endtask

  task automatic compare_all();
    chk("pos_x", pos_x, m_x);
    chk("pos_y", pos_y, m_yacc / 16);
    chk("vel_y", $signed(vel_y), m_vy);
    chk("action", action, m_act);
    chk("direction", direction, m_dir);
    chk("jumps_left", jumps_left, m_jumps);
  endtask

  task automatic cyc(input logic tk, input logic [3:0] k, input logic [3:0] col,
                     input logic rsp, input int sx = 0, input int sy = 0);
    tick = tk; keys = k; is_collide = col; respawn = rsp;
    spawn_x = sx[9:0]; spawn_y = sy[9:0];
    @(posedge clk);
    model_clk(tk, k, col, rsp, sx, sy);
    #1;
    compare_all();
    tick = 1'b0; respawn = 1'b0;
  endtask

  initial begin
    logic       tk, rsp;
    logic [3:0] k, col;

    model_reset();
    #12;
    chk("rst_x", pos_x, 200);
    chk("rst_y", pos_y, 556);
    chk("rst_vy", $signed(vel_y), 0);
    chk("rst_act", action, 0);
    chk("rst_dir", direction, 1);
    chk("rst_jumps", jumps_left, 2);
    @(negedge clk);
    rst_n = 1'b1;

    // Run right on the ground
    repeat (5) cyc(1, 4'b0010, 4'b0100, 0);
    chk("run_x", pos_x, 210);
    chk("run_act", action, 1);
    chk("run_dir", direction, 1);
    cyc(1, 4'b0110, 4'b0100, 0);
    chk("both_x", pos_x, 210);

    // Ground jump, then rising with gravity
    cyc(0, 4'b0000, 4'b0100, 0);
    cyc(1, 4'b0001, 4'b0000, 0);
    chk("jump_vy", $signed(vel_y), -64);
    chk("jump_y", pos_y, 552);
    chk("jump_jl", jumps_left, 1);
    chk("jump_act", action, 2);
    cyc(1, 4'b0001, 4'b0000, 0);
    chk("rise_vy", $signed(vel_y), -61);
    chk("rise_y", pos_y, 548);

    // Air jump, then exhausted jump, then held key
    cyc(0, 4'b0000, 4'b0000, 0);
    cyc(1, 4'b0001, 4'b0000, 0);
    chk("air_vy", $signed(vel_y), -52);
    chk("air_jl", jumps_left, 0);
    cyc(0, 4'b0000, 4'b0000, 0);
    cyc(1, 4'b0001, 4'b0000, 0);
    chk("third_vy", $signed(vel_y), -49);
    cyc(1, 4'b0001, 4'b0000, 0);
    chk("held_vy", $signed(vel_y), -46);

    // Fall to terminal velocity, then land
    repeat (60) cyc(1, 4'b0000, 4'b0000, 0);
    chk("term_vy", $signed(vel_y), 96);
    chk("floor_y", pos_y, 599);
    cyc(1, 4'b0000, 4'b0100, 0);
    chk("land_vy", $signed(vel_y), 0);
    chk("land_act", action, 0);
    chk("land_jl", jumps_left, 2);

    // Respawn wins over a simultaneous tick
    cyc(1, 4'b0010, 4'b0100, 1, 123, 321);
    chk("rsp_x", pos_x, 123);
    chk("rsp_y", pos_y, 321);
    chk("rsp_vy", $signed(vel_y), 0);
    chk("rsp_act", action, 3);

    // X clamps
    cyc(0, 4'b0000, 4'b0000, 1, 798, 300);
    cyc(1, 4'b0010, 4'b0100, 0);
    chk("xmax", pos_x, 799);
    cyc(0, 4'b0000, 4'b0000, 1, 1, 300);
    cyc(1, 4'b0100, 4'b0100, 0);
    chk("xmin", pos_x, 0);

    // Y clamp at top and ceiling collision
    cyc(0, 4'b0000, 4'b0000, 1, 100, 2);
    cyc(1, 4'b0000, 4'b0100, 0);
    cyc(1, 4'b0001, 4'b0100, 0);
    chk("ymin", pos_y, 0);
    cyc(0, 4'b0000, 4'b0000, 1, 100, 300);
    cyc(1, 4'b0000, 4'b0100, 0);
    cyc(1, 4'b0001, 4'b1100, 0);
    chk("ceil_vy", $signed(vel_y), 0);

    // Randomized frames
    for (int i = 0; i < 4000; i++) begin
      tk  = ($urandom_range(0, 2) == 0);
      rsp = ($urandom_range(0, 149) == 0);
      k   = 4'($urandom);
      col = 4'($urandom);
      if ($urandom_range(0, 3) == 0) col[2] = 1'b1;
      cyc(tk, k, col, rsp, $urandom_range(0, 799), $urandom_range(0, 599));
    end

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("arst_jl", jumps_left, 2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
